// File: rtl/modexp_ctrl_pkg.sv
// Shared definitions for the modular-exponentiation sequencer.
package modexp_ctrl_pkg;

    localparam int unsigned DefaultW = 1024;

    typedef enum logic [2:0] {
        StIdle,
        StSqGo,
        StSqWait,
        StMulGo,
        StMulWait,
        StFinGo,
        StFinWait,
        StDone
    } state_e;

    // Width needed to hold an exponent length in 0..w.
    function automatic int unsigned len_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer in the Montgomery domain, driving one
// external Montgomery multiplier and converting the result out with a final multiply by 1.
module modexp_ctrl
    import modexp_ctrl_pkg::*;
#(
    parameter int unsigned W     = DefaultW,
    parameter int unsigned LEN_W = len_width(W),
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [W-1:0]     x_mont,
    input  logic [W-1:0]     r_mod_m,
    input  logic [W-1:0]     modulus,
    input  logic [W-1:0]     exponent,
    input  logic [LEN_W-1:0] exp_len,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     result,
    output logic [CNT_W-1:0] mult_count,
    output logic             mult_start,
    output logic [W-1:0]     mult_a,
    output logic [W-1:0]     mult_b,
    output logic [W-1:0]     mult_m,
    input  logic             mult_done,
    input  logic [W+3:0]     mult_res
);

    state_e           state_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     xt_q;
    logic [W-1:0]     m_q;
    logic [W-1:0]     e_q;
    logic [LEN_W-1:0] idx_q;

    logic [W-1:0]     res_lo;
    logic [3:0]       unused_res_hi;
    logic [W-1:0]     e_shift;
    logic             bit_set;
    logic [LEN_W-1:0] len_clamped;

    assign res_lo        = mult_res[W-1:0];
    assign unused_res_hi = mult_res[W+3:W];

    // idx_q is already decremented when the square completes, so it names the current bit.
    assign e_shift = e_q >> idx_q;
    assign bit_set = e_shift[0];

    assign len_clamped = (exp_len > LEN_W'(W)) ? LEN_W'(W) : exp_len;

    assign mult_a = a_q;
    assign mult_m = m_q;

    always_comb begin
        mult_b = a_q;
        unique case (state_q)
            StMulGo, StMulWait: mult_b = xt_q;
            StFinGo, StFinWait: mult_b = W'(1);
            default:            mult_b = a_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            a_q        <= '0;
            xt_q       <= '0;
            m_q        <= '0;
            e_q        <= '0;
            idx_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            mult_count <= '0;
            mult_start <= 1'b0;
        end else begin
            // mult_start is raised on entry to each *_GO state, so it lasts exactly that cycle.
            mult_start <= 1'b0;
            done       <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        xt_q       <= x_mont;
                        m_q        <= modulus;
                        e_q        <= exponent;
                        a_q        <= r_mod_m;
                        idx_q      <= len_clamped;
                        mult_count <= '0;
                        busy       <= 1'b1;
                        mult_start <= 1'b1;
                        state_q    <= (len_clamped == '0) ? StFinGo : StSqGo;
                    end
                end
                StSqGo: begin
                    idx_q   <= idx_q - LEN_W'(1);
                    state_q <= StSqWait;
                    if (mult_count != '1) mult_count <= mult_count + CNT_W'(1);
                end
                StSqWait: begin
                    if (mult_done) begin
                        a_q        <= res_lo;
                        mult_start <= 1'b1;
                        if (bit_set)             state_q <= StMulGo;
                        else if (idx_q == '0)    state_q <= StFinGo;
                        else                     state_q <= StSqGo;
                    end
                end
                StMulGo: begin
                    state_q <= StMulWait;
                    if (mult_count != '1) mult_count <= mult_count + CNT_W'(1);
                end
                StMulWait: begin
                    if (mult_done) begin
                        a_q        <= res_lo;
                        mult_start <= 1'b1;
                        state_q    <= (idx_q == '0) ? StFinGo : StSqGo;
                    end
                end
                StFinGo: begin
                    state_q <= StFinWait;
                    if (mult_count != '1) mult_count <= mult_count + CNT_W'(1);
                end
                StFinWait: begin
                    if (mult_done) begin
                        result  <= res_lo;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Randomised self-checking bench for modexp_ctrl with a Montgomery multiplier model.
module tb_modexp_ctrl;

    localparam int W     = 8;
    localparam int LEN_W = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             start = 1'b0;
    logic [W-1:0]     x_mont = '0;
    logic [W-1:0]     r_mod_m = '0;
    logic [W-1:0]     modulus = '0;
    logic [W-1:0]     exponent = '0;
    logic [LEN_W-1:0] exp_len = '0;
    logic             busy;
    logic             done;
    logic [W-1:0]     result;
    logic [CNT_W-1:0] mult_count;
    logic             mult_start;
    logic [W-1:0]     mult_a;
    logic [W-1:0]     mult_b;
    logic [W-1:0]     mult_m;
    logic             mult_done;
    logic [W+3:0]     mult_res;

    modexp_ctrl #(
        .W     (W),
        .LEN_W (LEN_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .x_mont     (x_mont),
        .r_mod_m    (r_mod_m),
        .modulus    (modulus),
        .exponent   (exponent),
        .exp_len    (exp_len),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .mult_count (mult_count),
        .mult_start (mult_start),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .mult_m     (mult_m),
        .mult_done  (mult_done),
        .mult_res   (mult_res)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
    } op_t;

    op_t eq[$];
    int  errors = 0;
    int  checks = 0;
    int  ops_seen = 0;
    bit  in_op = 1'b0;
    int  lat = 5;
    int  cur_m = 13;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // a*b*2^-8 mod m, the inverse of 256 found by search.
    function automatic int mont(input int a, input int b, input int m);
        int ri;
        for (ri = 1; ri < m; ri++) if ((256 * ri) % m == 1) break;
        return ((a * b) % m) * ri % m;
    endfunction

    // Multiplier model: fixed latency, random junk in the upper result bits.
    int mcnt = 0;
    int ma = 0;
    int mb = 0;
    int mm = 13;
    bit mpend = 1'b0;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mpend = 1'b0;
            mcnt = 0;
            mult_done <= 1'b0;
            mult_res <= '0;
        end else begin
            mult_done <= 1'b0;
            if (mpend) begin
                mcnt--;
                if (mcnt <= 0) begin
                    mpend = 1'b0;
                    mult_done <= 1'b1;
                    mult_res <= {4'($urandom), 8'(mont(ma, mb, mm))};
                end
            end
            if (mult_start) begin
                mpend = 1'b1;
                ma = int'(mult_a);
                mb = int'(mult_b);
                mm = int'(mult_m);
                mcnt = lat;
            end
        end
    end

    // Per-cycle compare against the expected multiplier operation sequence.
    always @(negedge clk) begin
        op_t e;
        if (resetn) begin
            if (mult_start) begin
                ops_seen++;
                if (eq.size() == 0) begin
                    chk("unexpected_mult_start", 32'(mult_start), 32'(0));
                end else begin
                    e = eq.pop_front();
                    chk("mult_a", 32'(mult_a), 32'(e.a));
                    chk("mult_b", 32'(mult_b), 32'(e.b));
                end
            end else if (mpend) begin
                chk("mult_a_stable", 32'(mult_a), 32'(ma));
                chk("mult_b_stable", 32'(mult_b), 32'(mb));
            end
            if (in_op) begin
                chk("mult_m", 32'(mult_m), 32'(cur_m));
                if (!done) chk("busy", 32'(busy), 32'(1));
            end
        end
    end

    // Builds the expected op list and returns the expected result and multiply count.
    task automatic prep(input int x, input int e, input int len, input int m,
                        output int xt, output int want, output int cnt);
        int lenc, eu, a;
        lenc = (len > W) ? W : len;
        eu = (lenc >= W) ? (e & 255) : (e & ((1 << lenc) - 1));
        xt = (x * 256) % m;
        want = 1 % m;
        for (int i = 0; i < eu; i++) want = (want * x) % m;
        cnt = lenc + $countones(eu) + 1;
        a = 256 % m;
        for (int i = lenc - 1; i >= 0; i--) begin
            eq.push_back('{a, a});
            a = mont(a, a, m);
            if (((eu >> i) & 1) == 1) begin
                eq.push_back('{a, xt});
                a = mont(a, xt, m);
            end
        end
        eq.push_back('{a, 1});
        a = mont(a, 1, m);
        chk("model_vs_pow", 32'(a), 32'(want));
    endtask

    task automatic launch(input int xt, input int e, input int len, input int m);
        @(negedge clk);
        cur_m = m;
        x_mont = 8'(xt);
        r_mod_m = 8'(256 % m);
        modulus = 8'(m);
        exponent = 8'(e);
        exp_len = 4'(len);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        in_op = 1'b1;
    endtask

    task automatic run_op(input int x, input int e, input int len, input int m, input int l,
                          input bit pin, input int pin_res, input int pin_cnt, input bit poke);
        int xt, want, cnt, base;
        bit got, poked;
        got = 1'b0;
        poked = 1'b0;
        lat = l;
        prep(x, e, len, m, xt, want, cnt);
        if (pin) begin
            chk("pin_result", 32'(want), 32'(pin_res));
            chk("pin_count", 32'(cnt), 32'(pin_cnt));
        end
        launch(xt, e, len, m);
        base = ops_seen;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            if (poke && !poked && ops_seen >= base + 1) begin
                poked = 1'b1;
                x_mont = 8'hAA;
                r_mod_m = 8'h01;
                modulus = 8'h07;
                exponent = 8'h00;
                exp_len = 4'd1;
                start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
        in_op = 1'b0;
        chk("done_seen", 32'(got), 32'(1));
        chk("result", 32'(result), 32'(want));
        chk("mult_count", 32'(mult_count), 32'(cnt));
        chk("busy_at_done", 32'(busy), 32'(0));
        chk("ops_left", 32'(eq.size()), 32'(0));
        eq.delete();
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'(0));
        chk("result_hold", 32'(result), 32'(want));
    endtask

    task automatic reset_mid_op();
        int xt, want, cnt, base;
        lat = 5;
        prep(2, 5, 3, 13, xt, want, cnt);
        launch(xt, 5, 3, 13);
        base = ops_seen;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (ops_seen >= base + 2) break;
        end
        chk("reached_mul", 32'(ops_seen - base), 32'(2));
        repeat (2) @(negedge clk);
        #2;
        in_op = 1'b0;
        eq.delete();
        resetn = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_mult_start", 32'(mult_start), 32'(0));
        chk("rst_result", 32'(result), 32'(0));
        chk("rst_count", 32'(mult_count), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        int m, x;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_done", 32'(done), 32'(0));
        chk("reset_mult_start", 32'(mult_start), 32'(0));
        chk("reset_result", 32'(result), 32'(0));
        chk("reset_count", 32'(mult_count), 32'(0));
        chk("reset_mult_m", 32'(mult_m), 32'(0));
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        run_op(2, 5, 3, 13, 5, 1'b1, 6, 6, 1'b0);
        run_op(2, 0, 3, 13, 5, 1'b1, 1, 4, 1'b0);
        run_op(2, 255, 0, 13, 5, 1'b1, 1, 1, 1'b0);
        run_op(2, 5, 3, 13, 5, 1'b1, 6, 6, 1'b1);
        reset_mid_op();
        run_op(2, 5, 3, 13, 5, 1'b1, 6, 6, 1'b0);
        run_op(3, 255, 8, 13, 1, 1'b1, 1, 17, 1'b0);
        run_op(2, 5, 12, 13, 3, 1'b1, 6, 11, 1'b0);

        for (int t = 0; t < 25; t++) begin
            m = int'($urandom_range(1, 127)) * 2 + 1;
            x = int'($urandom_range(0, m - 1));
            run_op(x, int'($urandom_range(0, 255)), int'($urandom_range(0, 10)), m,
                   int'($urandom_range(1, 6)), 1'b0, 0, 0, ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
